vc_reg_fifo: RTL
================

VC_REG_FIFO -- requirements
Module: vc_reg_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, entries per virtual channel (>=2, any integer, not only powers of two).
REQ-003 SHALL have parameter NUM_VC, default 2, number of independent virtual channels (>=1).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_wr_en  input  1  write request.
REQ-007 SHALL have port i_wr_vc  input  max(1,$clog2(NUM_VC))  target VC of the write.
REQ-008 SHALL have port i_wr_dat  input  WIDTH  write data.
REQ-009 SHALL have port i_rd_en  input  1  read (pop) request.
REQ-010 SHALL have port i_rd_vc  input  max(1,$clog2(NUM_VC))  VC selected for read.
REQ-011 SHALL have port o_rd_dat  output  WIDTH  head entry of VC i_rd_vc (first-word-fall-through).
REQ-012 SHALL have port o_ful  output  NUM_VC  per-VC full flag, bit v = VC v.
REQ-013 SHALL have port o_empty  output  NUM_VC  per-VC empty flag.
REQ-014 SHALL have port o_cnt  output  NUM_VC*$clog2(DEPTH+1)  per-VC occupancy, VC v in slice v.

Function
REQ-015 SHALL store each VC in its own DEPTH-entry register array with a private write pointer, read pointer and counter.
REQ-016 SHALL wrap each pointer from DEPTH-1 to 0.
REQ-017 SHALL derive o_ful[v] = (cnt[v]==DEPTH) and o_empty[v] = (cnt[v]==0), registered-state only, no input path.
REQ-018 SHALL drive o_rd_dat combinationally from the head of VC i_rd_vc, with zero-cycle read latency; SHALL drive all zeros when that VC is empty.
REQ-019 SHALL make a written entry visible at o_rd_dat on the cycle after the write edge (write-to-read latency 1, no bypass).
REQ-020 SHALL accept a write iff i_wr_en=1 and (o_ful[i_wr_vc]=0 or a read of the same VC is accepted in the same cycle).
REQ-021 SHALL accept a read iff i_rd_en=1 and o_empty[i_rd_vc]=0.
REQ-022 SHALL ignore a rejected write or read with no change of any state.
REQ-023 SHALL leave the count unchanged on accepted simultaneous write and read to the same VC, and advance both pointers.
REQ-024 SHALL, on simultaneous write and read to an empty VC, reject the read, accept the write, and set cnt to 1.
REQ-025 SHALL update the counts of different VCs independently when write and read target different VCs in one cycle.
REQ-026 SHALL treat i_wr_vc/i_rd_vc values >= NUM_VC as rejected requests.

Reset
REQ-027 SHALL, while rst=1, asynchronously clear all pointers and counters: o_cnt=0, o_empty=all ones, o_ful=0, o_rd_dat=0.
REQ-028 SHALL discard all stored entries on reset mid-operation; storage contents need not be cleared.
REQ-029 SHALL accept the first write on the first rising clk edge after rst deasserts.

Configuration
REQ-030 SHALL, when macro VC_REG_FIFO_ERR_EN is defined, add outputs o_ovf and o_udf (each NUM_VC bits, sticky, reset 0).
REQ-031 SHALL set o_ovf[v] on a rejected write to VC v, and set o_udf[v] on a rejected read of VC v; a bit SHALL clear only on rst.
REQ-032 SHALL, without VC_REG_FIFO_ERR_EN, omit both ports and their logic with otherwise identical behaviour.

Verification
REQ-033 SHALL cover: DEPTH=2, NUM_VC=2; write 0x01, 0x02 to VC0 -> o_ful=2'b01, o_cnt VC0=2, o_rd_dat(rd_vc=0)=0x01, then 0x02 after one pop.
REQ-034 SHALL cover: VC0 full; write 0x03 to VC0 with no read -> rejected, cnt stays 2; with ERR_EN, o_ovf=2'b01.
REQ-035 SHALL cover: VC0 full; write 0x03 to VC0 and pop VC0 in the same cycle -> cnt stays 2, pops yield 0x02, 0x03.
REQ-036 SHALL cover: DEPTH=3; push 0x10..0x16 with interleaved pops -> in-order output across pointer wrap 2->0.
REQ-037 SHALL cover: write 0xAA to VC1 while popping VC0 (cnt 1) -> VC0 cnt 0, VC1 cnt 1, o_empty=2'b01.
REQ-038 SHALL cover: assert rst mid-stream with both VCs non-empty -> o_cnt=0, o_empty=2'b11 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vc_reg_fifo.sv
`default_nettype none
// ============================================================================
// Module  : vc_reg_fifo
// Brief   : Multi-virtual-channel register FIFO, first-word-fall-through read.
//           Optional sticky overflow/underflow flags: VC_REG_FIFO_ERR_EN.
// Revision: 1.0
// ============================================================================
module vc_reg_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int NUM_VC = 2,
    localparam int c_vcw = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int c_cw  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [c_vcw-1:0]         i_wr_vc,
    input  logic [WIDTH-1:0]         i_wr_dat,
    input  logic                     i_rd_en,
    input  logic [c_vcw-1:0]         i_rd_vc,
    output logic [WIDTH-1:0]         o_rd_dat,
    output logic [NUM_VC-1:0]        o_ful,
    output logic [NUM_VC-1:0]        o_empty,
    output logic [NUM_VC*c_cw-1:0]   o_cnt
`ifdef VC_REG_FIFO_ERR_EN
    ,
    output logic [NUM_VC-1:0]        o_ovf,
    output logic [NUM_VC-1:0]        o_udf
`endif
);

    localparam int c_pw = $clog2(DEPTH);
    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);
    localparam logic [c_pw-1:0] c_last = c_pw'(DEPTH - 1);

    logic [NUM_VC-1:0]             w_wr_sel;
    logic [NUM_VC-1:0]             w_rd_sel;
    logic [NUM_VC-1:0]             w_wr_acc;
    logic [NUM_VC-1:0]             w_rd_acc;
    logic [NUM_VC-1:0][WIDTH-1:0]  w_head;

    // Pointers wrap explicitly so DEPTH need not be a power of two
    function automatic logic [c_pw-1:0] f_nxt(input logic [c_pw-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [c_pw-1:0]  r_wp;
        logic [c_pw-1:0]  r_rp;
        logic [c_cw-1:0]  r_cnt;

        // Out-of-range VC selects match no channel, so they are rejected
        assign w_wr_sel[v] = i_wr_en && (i_wr_vc == c_vcw'(v));
        assign w_rd_sel[v] = i_rd_en && (i_rd_vc == c_vcw'(v));
        assign w_rd_acc[v] = w_rd_sel[v] && (r_cnt != '0);
        assign w_wr_acc[v] = w_wr_sel[v] && ((r_cnt != c_full) || w_rd_acc[v]);

        assign w_head[v]              = r_mem[r_rp];
        assign o_ful[v]               = (r_cnt == c_full);
        assign o_empty[v]             = (r_cnt == '0);
        assign o_cnt[v*c_cw +: c_cw]  = r_cnt;

        always_ff @(posedge clk) begin
            if (w_wr_acc[v]) begin
                r_mem[r_wp] <= i_wr_dat;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_wr_acc[v]) begin
                    r_wp <= f_nxt(r_wp);
                end
                if (w_rd_acc[v]) begin
                    r_rp <= f_nxt(r_rp);
                end
                if (w_wr_acc[v] && !w_rd_acc[v]) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (!w_wr_acc[v] && w_rd_acc[v]) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end

`ifdef VC_REG_FIFO_ERR_EN
        logic r_ovf;
        logic r_udf;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                if (w_wr_sel[v] && !w_wr_acc[v]) begin
                    r_ovf <= 1'b1;
                end
                if (w_rd_sel[v] && !w_rd_acc[v]) begin
                    r_udf <= 1'b1;
                end
            end
        end

        assign o_ovf[v] = r_ovf;
        assign o_udf[v] = r_udf;
`endif
    end

    always_comb begin
        o_rd_dat = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if ((i_rd_vc == c_vcw'(v)) && !o_empty[v]) begin
                o_rd_dat = w_head[v];
            end
        end
    end

endmodule
`default_nettype wire
